tdo_capture: RTL

TDO_CAPTURE -- requirements
Module: tdo_capture

---
 rtl/jtag_pkg.sv | 16 +
 rtl/tdo_capture_if.sv | 32 +++
 rtl/tdo_capture_shift_counter.sv | 26 ++
 rtl/tdo_capture.sv | 96 +++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: capture FSM states and the default chain length.
// No logic; types and constants only.
// Imported by the TDO capture block, the TDI generator and benches.
package jtag_pkg;

  // Default boundary-scan chain length in bits
  localparam int BSC_SIZE_DEF = 14;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/tdo_capture_if.sv
// Bundle of control, serial-data and result signals for the TDO capture block.
// No latency; wiring only.
// No backpressure; shift_enable qualifies every serial bit.
interface tdo_capture_if import jtag_pkg::*; #(
  parameter int BSC_SIZE = BSC_SIZE_DEF
);
  localparam int CW = $clog2(BSC_SIZE + 1);

  logic                from_TDO;
  logic                start;
  logic                shift_enable;
  logic [BSC_SIZE-1:0] expected_pattern;
  logic [BSC_SIZE-1:0] compare_mask;
  logic [BSC_SIZE-1:0] captured_pattern;
  logic [CW-1:0]       bit_count;
  logic                busy;
  logic                done;
  logic                match;
  logic                overrun;

  // Driver side (stimulus / TAP controller)
  modport master (
    output from_TDO, start, shift_enable, expected_pattern, compare_mask,
    input  captured_pattern, bit_count, busy, done, match, overrun
  );

  // Capture block side
  modport slave (
    input  from_TDO, start, shift_enable, expected_pattern, compare_mask,
    output captured_pattern, bit_count, busy, done, match, overrun
  );
endinterface

// File: rtl/tdo_capture_shift_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Count visible one cycle after the enabling edge.
// No backpressure; stops at MAX and ignores further enables.
module shift_counter #(
  parameter int W   = 4,
  parameter int MAX = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] CMAX = W'(MAX);

  // Clear wins over enable; hold once saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CMAX)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/tdo_capture.sv
// Assembles a BSC_SIZE-bit word from TDO (LSB first) and compares it to a masked reference.
// done/match rise one cycle after the last shifted bit; all outputs registered.
// No backpressure; shift_enable is accepted every cycle, extra bits in DONE set overrun.
module tdo_capture import jtag_pkg::*; #(
  parameter int BSC_SIZE = BSC_SIZE_DEF
) (
  input logic          TCK,
  input logic          reset,
  tdo_capture_if.slave cap
);
  localparam int            CW   = $clog2(BSC_SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(BSC_SIZE - 1);

  cap_state_t          state;
  logic [BSC_SIZE-1:0] word_q;
  logic [BSC_SIZE-1:0] exp_q;
  logic [BSC_SIZE-1:0] mask_q;
  logic [BSC_SIZE-1:0] word_nxt;
  logic                busy_q;
  logic                done_q;
  logic                match_q;
  logic                overrun_q;
  logic [CW-1:0]       count;
  logic                take_bit;

  // Word after accepting the current TDO bit into the MSB
  assign word_nxt = {cap.from_TDO, word_q[BSC_SIZE-1:1]};

  // A bit is accepted only in SHIFT and only when no restart is requested
  assign take_bit = (state == ST_SHIFT) && cap.shift_enable && !cap.start;

  shift_counter #(
    .W   (CW),
    .MAX (BSC_SIZE)
  ) u_cnt (
    .clk   (TCK),
    .rst   (reset),
    .clr   (cap.start),
    .en    (take_bit),
    .count (count)
  );

  // Capture FSM with registered status outputs
  always_ff @(posedge TCK or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      word_q    <= '0;
      exp_q     <= '0;
      mask_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (cap.start) begin
      // Arm from any state; an abort in SHIFT drops any bit offered this cycle
      state     <= ST_SHIFT;
      word_q    <= '0;
      exp_q     <= cap.expected_pattern;
      mask_q    <= cap.compare_mask;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (cap.shift_enable) begin
            word_q <= word_nxt;
            if (count == LAST) begin
              // Final bit: compare on the complete word, including this bit
              state   <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              match_q <= (((word_nxt ^ exp_q) & mask_q) == '0);
            end
          end
        end
        ST_DONE: begin
          if (cap.shift_enable) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cap.captured_pattern = word_q;
  assign cap.bit_count        = count;
  assign cap.busy             = busy_q;
  assign cap.done             = done_q;
  assign cap.match            = match_q;
  assign cap.overrun          = overrun_q;
endmodule
